// File: rtl/afu_csr_pkg.sv
// Shared constants for the multi-channel AFU CSR block: CSR slot map,
// STATUS bit positions and the packed STATUS layout.
package afu_csr_pkg;

   localparam int MAX_CH = 8;

   // CSR slot indices
   localparam int CSR_CMD       = 0;
   localparam int CSR_STATUS    = 1;
   localparam int CSR_CFG_SEL   = 2;
   localparam int CSR_CFG_DATA  = 3;
   localparam int CSR_RCP_PUSH  = 4;
   localparam int CSR_RCP_LEVEL = 5;
   localparam int CSR_RESULT0   = 6;

   // STATUS bit positions
   localparam int ST_DONE_LSB   = 0;
   localparam int ST_BUSY_LSB   = 8;
   localparam int ST_RCP_OVF    = 16;
   localparam int ST_CMD_REJECT = 17;
   localparam int ST_CFG_REJECT = 18;

   // STATUS read layout, LSB-aligned: done[7:0], busy[15:8], flags [18:16]
   typedef struct packed {
      logic              cfg_reject;
      logic              cmd_reject;
      logic              rcp_ovf;
      logic [MAX_CH-1:0] busy;
      logic [MAX_CH-1:0] done;
   } status_t;

endpackage

// File: rtl/afu_csr_fifo.sv
// Synchronous FIFO for recipe entries. The head is presented combinationally
// from storage, so an entry is visible the cycle after it is pushed; the head
// reads 0 while empty. A push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module afu_csr_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      level <= level + 1'b1;
         else if (do_pop && !do_push) level <= level - 1'b1;
      end
   end

   // Entry storage; contents need no reset because head is masked while empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/afu_csr_ctrl_mc.sv
// Multi-channel AFU CSR controller: decodes CPU MMIO writes into a start
// command, per-channel config registers, a recipe FIFO and sticky W1C status.
// All CPU read data passes through one register stage.
// Optional build macro: AFU_CSR_PERF_EN adds a saturating 32-bit start-to-done
// cycle counter in the upper half of each RESULT slot.
module afu_csr_ctrl_mc
   import afu_csr_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int NUM_CSRS  = 16,
   parameter int CFG_W     = 64,
   parameter int RCP_DEPTH = 16,
   parameter int RCP_W     = 64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        csr_wr_en,
   input  logic [$clog2(NUM_CSRS)-1:0] csr_wr_idx,
   input  logic [63:0]                 csr_wr_data,
   output logic [NUM_CSRS*64-1:0]      csr_rd_data,
   output logic                        cmd_start,
   output logic [NUM_CH-1:0]           cmd_ch_mask,
   output logic [3:0]                  cmd_recipe,
   output logic [NUM_CH*CFG_W-1:0]     cfg_ch,
   output logic                        rcp_valid,
   output logic [RCP_W-1:0]            rcp_data,
   input  logic                        rcp_ready,
   input  logic [NUM_CH-1:0]           ch_done,
   input  logic [NUM_CH*16-1:0]        ch_result,
   output logic                        busy
);

   localparam int IDX_W = $clog2(NUM_CSRS);
   localparam int LVL_W = $clog2(RCP_DEPTH) + 1;

   logic              wr_cmd, wr_status, wr_sel, wr_cfg, wr_push;
   logic [63:0]       w1c;
   logic [NUM_CH-1:0] busy_mask;
   logic [NUM_CH-1:0] done_q;
   logic [NUM_CH-1:0] start_mask;
   logic              rcp_ovf_q, cmd_rej_q, cfg_rej_q;
   logic              cmd_rej_set, cfg_rej_set, ovf_set;
   logic [2:0]        cfg_sel;
   logic [15:0]       result_q [NUM_CH];
   logic              fifo_full, fifo_empty, fifo_pop;
   logic [LVL_W-1:0]  fifo_level;
   logic [NUM_CSRS*64-1:0] rd_next;
   status_t           status;

   assign wr_cmd    = csr_wr_en && (csr_wr_idx == IDX_W'(CSR_CMD));
   assign wr_status = csr_wr_en && (csr_wr_idx == IDX_W'(CSR_STATUS));
   assign wr_sel    = csr_wr_en && (csr_wr_idx == IDX_W'(CSR_CFG_SEL));
   assign wr_cfg    = csr_wr_en && (csr_wr_idx == IDX_W'(CSR_CFG_DATA));
   assign wr_push   = csr_wr_en && (csr_wr_idx == IDX_W'(CSR_RCP_PUSH));
   assign w1c       = wr_status ? csr_wr_data : 64'h0;

   assign busy        = |busy_mask;
   assign start_mask  = (wr_cmd && !busy) ? csr_wr_data[NUM_CH-1:0] : '0;
   assign cmd_rej_set = wr_cmd && busy;
   assign fifo_pop    = rcp_ready && !fifo_empty;
   assign ovf_set     = wr_push && fifo_full && !fifo_pop;
   assign rcp_valid   = !fifo_empty;

   // Flag a config write aimed at a channel that is currently running
   always_comb begin
      cfg_rej_set = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_cfg && (cfg_sel == 3'(i)) && busy_mask[i]) cfg_rej_set = 1'b1;
      end
   end

   // Start pulse lasts one cycle; mask and recipe stay latched until the next start
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_start   <= 1'b0;
         cmd_ch_mask <= '0;
         cmd_recipe  <= '0;
      end else begin
         cmd_start <= |start_mask;
         if (|start_mask) begin
            cmd_ch_mask <= start_mask;
            cmd_recipe  <= csr_wr_data[11:8];
         end
      end
   end

   // Busy tracking and sticky flags; a start or set always beats a same-cycle clear
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_mask <= '0;
         done_q    <= '0;
         rcp_ovf_q <= 1'b0;
         cmd_rej_q <= 1'b0;
         cfg_rej_q <= 1'b0;
      end else begin
         busy_mask <= (busy_mask & ~ch_done) | start_mask;
         done_q    <= (done_q & ~w1c[NUM_CH-1:0]) | ch_done;
         rcp_ovf_q <= (rcp_ovf_q & ~w1c[ST_RCP_OVF])    | ovf_set;
         cmd_rej_q <= (cmd_rej_q & ~w1c[ST_CMD_REJECT]) | cmd_rej_set;
         cfg_rej_q <= (cfg_rej_q & ~w1c[ST_CFG_REJECT]) | cfg_rej_set;
      end
   end

   // Channel select and per-channel config; out-of-range selects write nothing
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_sel <= '0;
         cfg_ch  <= '0;
      end else begin
         if (wr_sel) cfg_sel <= csr_wr_data[2:0];
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_cfg && (cfg_sel == 3'(i)) && !busy_mask[i])
               cfg_ch[i*CFG_W +: CFG_W] <= CFG_W'(csr_wr_data);
         end
      end
   end

   // Capture each engine's timing result on its done pulse
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (reset)           result_q[i] <= '0;
         else if (ch_done[i]) result_q[i] <= ch_result[16*i +: 16];
      end
   end

`ifdef AFU_CSR_PERF_EN
   logic [31:0] perf_q [NUM_CH];

   // Saturating start-to-done cycle counter per channel, zeroed on that channel's start
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (reset || start_mask[i])                       perf_q[i] <= '0;
         else if (busy_mask[i] && !ch_done[i] && perf_q[i] != '1) perf_q[i] <= perf_q[i] + 1'b1;
      end
   end
`endif

   // Assemble the CPU-visible read image; unmapped slots read zero
   always_comb begin
      rd_next           = '0;
      status            = '0;
      status.done       = MAX_CH'(done_q);
      status.busy       = MAX_CH'(busy_mask);
      status.rcp_ovf    = rcp_ovf_q;
      status.cmd_reject = cmd_rej_q;
      status.cfg_reject = cfg_rej_q;
      rd_next[64*CSR_STATUS +: 64]    = 64'(status);
      rd_next[64*CSR_RCP_LEVEL +: 64] = 64'(fifo_level);
      for (int i = 0; i < NUM_CH; i++) begin
         if (CSR_RESULT0 + i < NUM_CSRS) begin
`ifdef AFU_CSR_PERF_EN
            rd_next[64*(CSR_RESULT0+i) +: 64] = {perf_q[i], 16'h0, result_q[i]};
`else
            rd_next[64*(CSR_RESULT0+i) +: 64] = {48'h0, result_q[i]};
`endif
         end
      end
   end

   // Register the read image so the CSR manager always sees a flopped value
   always_ff @(posedge clk) begin
      if (reset) csr_rd_data <= '0;
      else       csr_rd_data <= rd_next;
   end

   afu_csr_fifo #(
      .DEPTH (RCP_DEPTH),
      .WIDTH (RCP_W)
   ) u_rcp_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (wr_push),
      .push_data (csr_wr_data[RCP_W-1:0]),
      .pop       (fifo_pop),
      .head      (rcp_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

endmodule

// File: doc/afu_csr_ctrl_mc.md
Name: afu_csr_ctrl_mc

Overview:
Parametrised successor to the single-channel AFU CSR block. Decodes CPU MMIO writes into a command pulse, per-channel configuration registers, a recipe FIFO with ready/valid pop, and sticky per-channel done/overflow status with write-1-to-clear. Sits between the CCI-P CSR manager and the multi-channel eviction-set / timing engines. All CPU-visible read data is registered.

Parameters:
NUM_CH, 4, number of engine channels (1..8)
NUM_CSRS, 16, CSR slots decoded (power of 2, >= 8)
CFG_W, 64, width of each per-channel config register
RCP_DEPTH, 16, recipe FIFO depth (power of 2, >= 2)
RCP_W, 64, recipe entry width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
csr_wr_en  in  1  CPU write strobe
csr_wr_idx  in  $clog2(NUM_CSRS)  CSR index of write
csr_wr_data  in  64  CPU write data
csr_rd_data  out  NUM_CSRS*64  flattened read data, slot i at [64*i+:64]
cmd_start  out  1  one-cycle start pulse
cmd_ch_mask  out  NUM_CH  channels targeted by start
cmd_recipe  out  4  recipe index latched with start
cfg_ch  out  NUM_CH*CFG_W  per-channel config registers
rcp_valid  out  1  recipe FIFO non-empty
rcp_data  out  RCP_W  FIFO head
rcp_ready  in  1  consumer pop
ch_done  in  NUM_CH  done pulses from engines
ch_result  in  NUM_CH*16  engine timing results
busy  out  1  any channel started and not yet done

Behaviour:
- Reset: cmd_start=0, cmd_ch_mask=0, cmd_recipe=0, cfg_ch all 0, FIFO empty (rcp_valid=0, rcp_data=0), busy=0, all sticky flags 0, csr_rd_data=0.
- CSR map: 0 CMD (W), 1 STATUS (R; W1C), 2 CFG_SEL (W), 3 CFG_DATA (W), 4 RCP_PUSH (W), 5 RCP_LEVEL (R), 6..6+NUM_CH-1 RESULT[ch] (R); remaining slots read 0, writes ignored.
- CMD write, not busy: next cycle cmd_start=1 for exactly one cycle; cmd_ch_mask=data[NUM_CH-1:0]; cmd_recipe=data[11:8]; busy mask |= ch_mask. A mask of 0 produces no pulse. CMD write while busy: dropped, sets sticky cmd_reject.
- CFG_SEL latches channel index data[2:0]; an out-of-range index makes later CFG_DATA writes no-ops. CFG_DATA writes cfg_ch[sel], truncated to CFG_W. Ignored (sticky cfg_reject) while the selected channel is busy.
- RCP_PUSH: push data[RCP_W-1:0]. Full: drop and set sticky rcp_ovf. Push and pop in the same cycle when full: pop occurs, push accepted, no overflow. Pop on rcp_valid&&rcp_ready; the head is valid the cycle after the first push (1-cycle latency). Pop when empty: no effect.
- ch_done[i] pulse: sets sticky done[i], clears busy bit i, captures ch_result[i] into RESULT[i]. A done pulse in the same cycle as the start for that channel is treated as start-wins (busy stays set, done still latched).
- STATUS read: [NUM_CH-1:0] done, [15:8] busy mask, [16] rcp_ovf, [17] cmd_reject, [18] cfg_reject. Write: bits written 1 clear the matching sticky bit. Set and clear in the same cycle: set wins.
- RCP_LEVEL read: occupancy 0..RCP_DEPTH, width $clog2(RCP_DEPTH)+1.
- Read data: all inputs to csr_rd_data are registered; 1-cycle latency from state change to visibility.
- Reset mid-operation: everything returns to reset values on the next edge; in-flight pulses are dropped.

Optional Feature:
AFU_CSR_PERF_EN: when defined, each RESULT slot upper 32 bits hold a saturating 32-bit cycle counter from start to done of that channel, cleared on that channel's start. When undefined, upper bits read 0 and no counter logic is synthesised.

Decomposition:
- Package afu_csr_pkg: CSR index localparams (CSR_CMD, CSR_STATUS, ...), STATUS bit-position constants, status_t packed struct, MAX_CH=8.
- Sub-module afu_csr_fifo: synchronous FIFO with push, pop, full, empty, and level outputs, parametrised by depth and width.

Test Plan:
- CMD write 0x0000_0305 when idle -> cmd_start is a 1-cycle pulse, ch_mask=4'b0101, recipe=3, busy=0x05; second CMD before done -> no pulse, STATUS[17]=1.
- CFG_SEL=2, CFG_DATA=0xDEAD_BEEF -> cfg_ch[2]=0xDEADBEEF, other channels unchanged; repeat while ch2 is busy -> unchanged, STATUS[18]=1.
- Push 17 recipes with depth 16, no pop -> RCP_LEVEL=16, STATUS[16]=1; pop all -> data in order 0..15, level 0.
- Full FIFO with simultaneous push and pop -> level stays 16, no overflow.
- ch_done[1] with ch_result[1]=0x01F4 -> STATUS[1]=1, RESULT[1]=0x1F4, busy bit 1 cleared; write STATUS=0x2 -> bit cleared; W1C in the same cycle as a new done -> bit stays 1.
- Assert reset while busy with FIFO half full -> all outputs return to reset values after 1 edge.
